// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered I-type decode stage with a 2-entry skid buffer.
// Extracts opcode/rt, extends the 16-bit immediate at write time and holds the
// result in a small FIFO so one cycle of downstream stall costs no bubble.
// LUI leaves the immediate zero-extended and flags is_lui; the <<16 happens in
// the shift_left16 stage that follows.
module imm_extend_stage #(
  parameter int          DEPTH  = 2,
  parameter logic [5:0]  OP_LUI = 6'h0F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] imm_ext,
  output logic        is_lui,
  output logic [5:0]  opcode,
  output logic [4:0]  rt,
  output logic [1:0]  count
);

  // Occupancy at which the buffer refuses new input. Only DEPTH=2 works with
  // the 1-bit pointers below.
  localparam logic [1:0] FULL_COUNT = DEPTH[1:0];

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  logic [31:0] imm_mem [2];
  logic        lui_mem [2];
  logic [5:0]  op_mem  [2];
  logic [4:0]  rt_mem  [2];

  logic        wr_ptr;
  logic        rd_ptr;
  logic        ready_q;
  logic [1:0]  count_q;
  logic [1:0]  count_next;

  logic        accept;
  logic        pop;

  logic [5:0]  new_op;
  logic [31:0] new_imm;
  logic        new_lui;

  assign accept    = in_valid & ready_q;
  assign pop       = (count_q != 2'd0) & out_ready;

  assign in_ready  = ready_q;
  assign out_valid = (count_q != 2'd0);
  assign count     = count_q;

  assign imm_ext   = imm_mem[rd_ptr];
  assign is_lui    = lui_mem[rd_ptr];
  assign opcode    = op_mem[rd_ptr];
  assign rt        = rt_mem[rd_ptr];

  // Decode the incoming word: logical ops and LUI zero-extend, everything else sign-extends.
  always_comb begin
    new_op  = instr[31:26];
    new_imm = {{16{instr[15]}}, instr[15:0]};
    new_lui = 1'b0;
    if (new_op == OP_LUI) begin
      new_imm = {16'h0000, instr[15:0]};
      new_lui = 1'b1;
    end else if ((new_op == OP_ANDI) || (new_op == OP_ORI) || (new_op == OP_XORI)) begin
      new_imm = {16'h0000, instr[15:0]};
    end
  end

  // Next occupancy from the accept/pop pair; simultaneous accept and pop cancel.
  always_comb begin
    count_next = count_q;
    case ({accept, pop})
      2'b10:   count_next = count_q + 2'd1;
      2'b01:   count_next = count_q - 2'd1;
      default: count_next = count_q;
    endcase
  end

  // Pointers, occupancy and the registered ready flag derived from next occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count_q <= count_next;
      ready_q <= (count_next != FULL_COUNT);
    end
  end

  // Entry storage; extension is done here so the read side is a plain mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        imm_mem[i] <= 32'h0;
        lui_mem[i] <= 1'b0;
        op_mem[i]  <= 6'h0;
        rt_mem[i]  <= 5'h0;
      end
    end else if (accept) begin
      imm_mem[wr_ptr] <= new_imm;
      lui_mem[wr_ptr] <= new_lui;
      op_mem[wr_ptr]  <= new_op;
      rt_mem[wr_ptr]  <= instr[20:16];
    end
  end

endmodule
